bsram_dp_be: RTL and testbench
==============================

Name: bsram_dp_be

Overview:
- Parametrised true dual-port block RAM. Successor to the basic dual-port BSRAM.
- Adds per-byte write enables, a selectable read-during-write mode and an optional output pipeline register.
- Adds write-collision detection and a hardware clear engine that zero-fills the array after reset or on request.
- Sits between the core/DMA masters and on-chip memory; one instance per memory region.

Parameters:
- A_SIZE, 10, address width in bits
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**A_SIZE
- W_SIZE, 32, word width; must be a multiple of 8
- NB, W_SIZE/8, number of byte lanes (derived; do not override)
- WR_MODE, 0, read-during-write on the same port: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register, giving read latency 2

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- cea, ceb  in  1  port A/B enable
- wea, web  in  NB  port A/B byte write enables; bit i covers byte [8i+7:8i]
- addra, addrb  in  A_SIZE  port A/B address
- dina, dinb  in  W_SIZE  port A/B write data
- douta, doutb  out  W_SIZE  port A/B read data
- clr  in  1  one-cycle pulse that requests a full zero-fill
- busy  out  1  clear engine active; all port accesses are ignored while high
- coll  out  1  one-cycle pulse on a same-address write/write collision
- perr_a, perr_b  out  1  parity error, aligned with douta/doutb (only with BSRAM_PARITY_EN)

Behaviour:
- Reset values:
  - douta = doutb = 0; OUT_REG stages = 0.
  - coll = perr_a = perr_b = 0.
  - busy = 1. The FSM is in CLEAR with counter = 0.
  - Array contents are not reset directly; the clear engine zero-fills them.
- Clear FSM:
  - States are IDLE and CLEAR.
  - CLEAR writes 0 (with correct parity) to address cnt each cycle, then cnt++.
  - At cnt == DEPTH-1 the FSM writes the last word and goes to IDLE. busy falls on the following cycle, so clear takes exactly DEPTH cycles after reset release.
  - IDLE & clr: go to CLEAR with cnt = 0.
  - clr during CLEAR restarts cnt at 0.
  - Reset asserted mid-clear re-enters CLEAR with cnt = 0.
- Access while busy: ce is ignored. Outputs hold their value. No writes occur and no collision is flagged.
- Access (IDLE, ce = 1):
  - Each byte i with we[i] = 1 is written.
  - A read occurs when we == 0, or according to WR_MODE when we != 0:
    - READ_FIRST: dout gets the old word.
    - WRITE_FIRST: dout gets the merged new word (new bytes where we = 1, old bytes elsewhere).
    - NO_CHANGE: dout holds.
- Latency and hold:
  - OUT_REG = 0: read data appears on dout on the edge after ce.
  - OUT_REG = 1: stage 1 as above; stage 2 copies stage 1 every cycle, so data appears one cycle later.
  - dout holds whenever ce = 0.
- Cross-port same address, same cycle:
  - A writes, B reads: B returns the old data. The same rule applies with A and B swapped.
  - Both write: port A wins for every byte lane where wea is set. Port B's bytes land only in lanes where wea = 0.
  - coll pulses 1 for one cycle whenever both ports write the same address with (wea & web) != 0.
- Out of range (addr >= DEPTH): the write is dropped and the read returns 0. There is no wrap-around.

Optional Feature:
- Macro: BSRAM_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte, computed on write.
  - On read, parity is checked per byte. perr_x = OR of the byte mismatches, registered alongside dout with the same latency.
  - The clear engine writes parity 0.
- Undefined: no parity storage; perr_a and perr_b are tied to 0.

Decomposition:
- Package bsram_pkg holds:
  - The wr_mode_e enum (READ_FIRST, WRITE_FIRST, NO_CHANGE).
  - The clr_state_e enum (IDLE, CLEAR).
  - Function byte_merge(old, new, be).
  - Function byte_parity(word) returning an NB-bit vector.
- Sub-module bsram_clr_fsm owns the counter and busy, and outputs clr_we, clr_addr.
- Memory, port muxing and output pipeline stay in the top module.

Test Plan:
- Reset release with DEPTH = 16 -> busy = 1 for exactly 16 cycles, then 0. A read of any address then returns 0, with perr = 0.
- READ_FIRST, word at A:3 = 0x11223344; A writes 0xAABBCCDD at 3 with wea = 4'b0101 -> douta = 0x11223344 next cycle; a later read gives 0x11BB33DD.
- WRITE_FIRST with the same stimulus -> douta = 0x11BB33DD on the write's cycle+1. With OUT_REG = 1 it appears at cycle+2, and the value at cycle+1 is the prior dout.
- Both ports write addr 5: A 0xFFFFFFFF with wea = 4'b0011, B 0x12345678 with web = 4'b1111 -> coll = 1 for one cycle; readback 0x1234FFFF.
- clr pulsed mid-traffic; a write to addr 2 issued while busy -> the write is ignored, outputs hold, and addr 2 reads 0 after busy falls. Reset asserted at cnt = 7 -> busy stays high for a full DEPTH cycles afterwards.
- BSRAM_PARITY_EN: force one stored bit flip via hierarchical poke at addr 9, then read on port B -> perr_b = 1 aligned with doutb. Addr = DEPTH read -> dout = 0, with no write side effect.

Source files
------------

// File: rtl/bsram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port block RAM.
// Optional parity storage is selected with the BSRAM_PARITY_EN macro.
package bsram_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend and slice.
    localparam int W_MAX  = 256;
    localparam int NB_MAX = W_MAX / 8;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } wr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // New bytes where be is set, old bytes everywhere else.
    function automatic logic [W_MAX-1:0] byte_merge(input logic [W_MAX-1:0]  old_w,
                                                    input logic [W_MAX-1:0]  new_w,
                                                    input logic [NB_MAX-1:0] be);
        logic [W_MAX-1:0] res;
        for (int i = 0; i < NB_MAX; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Even parity per byte: the stored bit makes the byte plus parity even.
    function automatic logic [NB_MAX-1:0] byte_parity(input logic [W_MAX-1:0] word);
        logic [NB_MAX-1:0] res;
        for (int i = 0; i < NB_MAX; i++) begin
            res[i] = ^word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bsram_clr_fsm.sv
// Clear engine: after reset or a clr pulse it sweeps every address once,
// asking the array to store zero, and holds busy high while doing so.
module bsram_clr_fsm
    import bsram_pkg::*;
#(
    parameter int A_SIZE = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [A_SIZE-1:0] clr_addr
);

    localparam logic [A_SIZE-1:0] LAST = A_SIZE'(DEPTH - 1);

    clr_state_e        state, state_nxt;
    logic [A_SIZE-1:0] cnt, cnt_nxt;

    // State and sweep counter; reset always starts a fresh sweep from address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; a clr seen mid-sweep restarts the sweep at 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/bsram_dp_be.sv
// True dual-port block RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a zero-fill clear engine.
// Define BSRAM_PARITY_EN to store and check one even-parity bit per byte.
module bsram_dp_be
    import bsram_pkg::*;
#(
    parameter int A_SIZE  = 10,
    parameter int DEPTH   = 1024,
    parameter int W_SIZE  = 32,
    parameter int NB      = W_SIZE / 8,
    parameter int WR_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cea,
    input  logic              ceb,
    input  logic [NB-1:0]     wea,
    input  logic [NB-1:0]     web,
    input  logic [A_SIZE-1:0] addra,
    input  logic [A_SIZE-1:0] addrb,
    input  logic [W_SIZE-1:0] dina,
    input  logic [W_SIZE-1:0] dinb,
    output logic [W_SIZE-1:0] douta,
    output logic [W_SIZE-1:0] doutb,
    input  logic              clr,
    output logic              busy,
    output logic              coll,
    output logic              perr_a,
    output logic              perr_b
);

    localparam wr_mode_e MODE = wr_mode_e'(WR_MODE[1:0]);
    localparam int       IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              clr_we;
    logic [A_SIZE-1:0] clr_addr;

    bsram_clr_fsm #(.A_SIZE(A_SIZE), .DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [W_SIZE-1:0] mem [0:DEPTH-1];

    logic              in_a, in_b;
    logic [IW-1:0]     ia, ib, ic;
    logic [W_SIZE-1:0] old_a, old_b, rd_a, rd_b;
    logic [W_MAX-1:0]  mrg_a_full, mrg_b_full;
    logic [NB-1:0]     wen_a, wen_b;
    logic              rd_en_a, rd_en_b, coll_d;
    logic [W_SIZE-1:0] s1a, s1b;

    // Addresses at or beyond DEPTH never alias onto a real word.
    assign in_a  = (32'(addra) < DEPTH);
    assign in_b  = (32'(addrb) < DEPTH);
    assign ia    = addra[IW-1:0];
    assign ib    = addrb[IW-1:0];
    assign ic    = clr_addr[IW-1:0];
    assign old_a = in_a ? mem[ia] : '0;
    assign old_b = in_b ? mem[ib] : '0;

    // Port gating, A-over-B lane priority, read selection and collision detect.
    always_comb begin
        mrg_a_full = byte_merge(W_MAX'(old_a), W_MAX'(dina), NB_MAX'(wea));
        mrg_b_full = byte_merge(W_MAX'(old_b), W_MAX'(dinb), NB_MAX'(web));
        wen_a      = (!busy && cea && in_a) ? wea : '0;
        wen_b      = (!busy && ceb && in_b) ? web : '0;
        if (addra == addrb) begin
            wen_b = wen_b & ~wen_a;
        end
        rd_en_a = !busy && cea && ((wea == '0) || (MODE != NO_CHANGE));
        rd_en_b = !busy && ceb && ((web == '0) || (MODE != NO_CHANGE));
        rd_a    = ((MODE == WRITE_FIRST) && in_a) ? mrg_a_full[W_SIZE-1:0] : old_a;
        rd_b    = ((MODE == WRITE_FIRST) && in_b) ? mrg_b_full[W_SIZE-1:0] : old_b;
        coll_d  = !busy && cea && ceb && in_a && in_b && (addra == addrb) && ((wea & web) != '0);
    end

    // Array write port: the clear engine owns the array while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ic] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wen_a[i]) mem[ia][8*i +: 8] <= dina[8*i +: 8];
                if (wen_b[i]) mem[ib][8*i +: 8] <= dinb[8*i +: 8];
            end
        end
    end

    // First output stage and collision pulse; outputs hold when nothing is read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1a  <= '0;
            s1b  <= '0;
            coll <= 1'b0;
        end else begin
            if (rd_en_a) s1a <= rd_a;
            if (rd_en_b) s1b <= rd_b;
            coll <= coll_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [W_SIZE-1:0] s2a, s2b;
        // Second stage copies the first every cycle for one extra cycle of latency.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2a <= '0;
                s2b <= '0;
            end else begin
                s2a <= s1a;
                s2b <= s1b;
            end
        end
        assign douta = s2a;
        assign doutb = s2b;
    end else begin : g_noreg
        assign douta = s1a;
        assign doutb = s1b;
    end

`ifdef BSRAM_PARITY_EN
    logic [NB-1:0]     pmem [0:DEPTH-1];
    logic [NB_MAX-1:0] pin_a_full, pin_b_full, pold_a_full, pold_b_full;
    logic [NB-1:0]     pst_a, pst_b, chk_a, chk_b;
    logic              err_a, err_b, pe1a, pe1b;

    // Parity of incoming and stored data; freshly merged lanes are not checked.
    always_comb begin
        pin_a_full  = byte_parity(W_MAX'(dina));
        pin_b_full  = byte_parity(W_MAX'(dinb));
        pold_a_full = byte_parity(W_MAX'(old_a));
        pold_b_full = byte_parity(W_MAX'(old_b));
        pst_a       = in_a ? pmem[ia] : '0;
        pst_b       = in_b ? pmem[ib] : '0;
        chk_a       = (MODE == WRITE_FIRST) ? ~wea : '1;
        chk_b       = (MODE == WRITE_FIRST) ? ~web : '1;
        err_a       = in_a && (((pold_a_full[NB-1:0] ^ pst_a) & chk_a) != '0);
        err_b       = in_b && (((pold_b_full[NB-1:0] ^ pst_b) & chk_b) != '0);
    end

    // Parity array follows the data array lane for lane.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            pmem[ic] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wen_a[i]) pmem[ia][i] <= pin_a_full[i];
                if (wen_b[i]) pmem[ib][i] <= pin_b_full[i];
            end
        end
    end

    // Parity error flag registered alongside the first data stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe1a <= 1'b0;
            pe1b <= 1'b0;
        end else begin
            if (rd_en_a) pe1a <= err_a;
            if (rd_en_b) pe1b <= err_b;
        end
    end

    if (OUT_REG != 0) begin : g_preg
        logic pe2a, pe2b;
        // Keeps the error flag aligned with the registered data output.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pe2a <= 1'b0;
                pe2b <= 1'b0;
            end else begin
                pe2a <= pe1a;
                pe2b <= pe1b;
            end
        end
        assign perr_a = pe2a;
        assign perr_b = pe2b;
    end else begin : g_pnoreg
        assign perr_a = pe1a;
        assign perr_b = pe1b;
    end

    logic unused_bits;
    assign unused_bits = ^{mrg_a_full, mrg_b_full, pin_a_full, pin_b_full, pold_a_full, pold_b_full};
`else
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{mrg_a_full, mrg_b_full};
`endif

endmodule

// File: tb/tb_bsram_dp_be.sv
// Bench for bsram_dp_be: three instances (READ_FIRST/no out reg,
// WRITE_FIRST/out reg, NO_CHANGE/no out reg) share one stimulus stream and
// are compared every cycle against a word-level model of the memory.
// Parity poke checks are compiled only when BSRAM_PARITY_EN is defined.
module tb_bsram_dp_be;

    localparam int AW  = 5;
    localparam int DEP = 16;

    logic        clk;
    logic        reset;
    logic        cea, ceb, clr;
    logic [3:0]  wea, web;
    logic [4:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] douta_d [3];
    logic [31:0] doutb_d [3];
    logic        busy_d  [3];
    logic        coll_d  [3];
    logic        perra_d [3];
    logic        perrb_d [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bsram_dp_be #(
            .A_SIZE (AW),
            .DEPTH  (DEP),
            .W_SIZE (32),
            .WR_MODE(g),
            .OUT_REG((g == 1) ? 1 : 0)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .cea    (cea),
            .ceb    (ceb),
            .wea    (wea),
            .web    (web),
            .addra  (addra),
            .addrb  (addrb),
            .dina   (dina),
            .dinb   (dinb),
            .douta  (douta_d[g]),
            .doutb  (doutb_d[g]),
            .clr    (clr),
            .busy   (busy_d[g]),
            .coll   (coll_d[g]),
            .perr_a (perra_d[g]),
            .perr_b (perrb_d[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    bit [31:0] ref_mem [DEP];
    bit [3:0]  ref_bad [DEP];
    bit        m_clearing;
    int        m_cnt;
    bit        m_coll;
    bit [31:0] m_s1a [3], m_s2a [3], m_s1b [3], m_s2b [3];
    bit        m_p1a [3], m_p2a [3], m_p1b [3], m_p2b [3];

    function automatic bit [31:0] merge(input bit [31:0] old_w, input bit [31:0] new_w, input bit [3:0] be);
        bit [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    // mode 0 read-first, 1 write-first, 2 no-change
    function automatic bit does_read(input int mode, input bit [3:0] we);
        return (we == 4'h0) || (mode != 2);
    endfunction

    function automatic bit [31:0] read_val(input int mode, input bit inr, input bit [31:0] old_w,
                                           input bit [31:0] din, input bit [3:0] we);
        if (!inr) return 32'h0;
        return (mode == 1) ? merge(old_w, din, we) : old_w;
    endfunction

    function automatic bit read_err(input int mode, input bit inr, input bit [3:0] bad, input bit [3:0] we);
        if (!inr) return 1'b0;
        return (bad & ((mode == 1) ? ~we : 4'hF)) != 4'h0;
    endfunction

    // Model update on every rising edge from the inputs that were presented.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clearing = 1'b1;
            m_cnt      = 0;
            m_coll     = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_s1a[c] = '0; m_s2a[c] = '0; m_s1b[c] = '0; m_s2b[c] = '0;
                m_p1a[c] = 0;  m_p2a[c] = 0;  m_p1b[c] = 0;  m_p2b[c] = 0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                m_s2a[c] = m_s1a[c]; m_s2b[c] = m_s1b[c];
                m_p2a[c] = m_p1a[c]; m_p2b[c] = m_p1b[c];
            end
            if (m_clearing) begin
                ref_mem[m_cnt] = '0;
                ref_bad[m_cnt] = '0;
                m_coll = 1'b0;
                if (clr) m_cnt = 0;
                else if (m_cnt == DEP - 1) m_clearing = 1'b0;
                else m_cnt++;
            end else begin
                bit        ina, inb;
                bit [31:0] olda, oldb;
                bit [3:0]  bada, badb;
                ina  = int'(addra) < DEP;
                inb  = int'(addrb) < DEP;
                olda = ina ? ref_mem[addra] : '0;
                oldb = inb ? ref_mem[addrb] : '0;
                bada = ina ? ref_bad[addra] : '0;
                badb = inb ? ref_bad[addrb] : '0;
                for (int c = 0; c < 3; c++) begin
                    if (cea && does_read(c, wea)) begin
                        m_s1a[c] = read_val(c, ina, olda, dina, wea);
                        m_p1a[c] = read_err(c, ina, bada, wea);
                    end
                    if (ceb && does_read(c, web)) begin
                        m_s1b[c] = read_val(c, inb, oldb, dinb, web);
                        m_p1b[c] = read_err(c, inb, badb, web);
                    end
                end
                m_coll = cea && ceb && ina && inb && (addra == addrb) && ((wea & web) != 4'h0);
                // B first, then A on top, so port A owns any shared lane.
                if (ceb && inb) begin
                    ref_mem[addrb] = merge(ref_mem[addrb], dinb, web);
                    ref_bad[addrb] = ref_bad[addrb] & ~web;
                end
                if (cea && ina) begin
                    ref_mem[addra] = merge(ref_mem[addra], dina, wea);
                    ref_bad[addra] = ref_bad[addra] & ~wea;
                end
                if (clr) begin
                    m_clearing = 1'b1;
                    m_cnt      = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s dut%0d at %0t: got 0x%08h, expected 0x%08h", name, c, $time, act, exp);
        end
    endtask

    // Every cycle out of reset, all outputs of all instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 3; c++) begin
                checkOutput("busy", c, 32'(busy_d[c]), 32'(m_clearing));
                checkOutput("coll", c, 32'(coll_d[c]), 32'(m_coll));
                checkOutput("douta", c, douta_d[c], (c == 1) ? m_s2a[c] : m_s1a[c]);
                checkOutput("doutb", c, doutb_d[c], (c == 1) ? m_s2b[c] : m_s1b[c]);
                checkOutput("perr_a", c, 32'(perra_d[c]), 32'((c == 1) ? m_p2a[c] : m_p1a[c]));
                checkOutput("perr_b", c, 32'(perrb_d[c]), 32'((c == 1) ? m_p2b[c] : m_p1b[c]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        cea = 0; ceb = 0; wea = 0; web = 0; addra = 0; addrb = 0;
        dina = 0; dinb = 0; clr = 0;
    endtask

    // Present one cycle of inputs, then return #1 after the edge that took them.
    task automatic applyStimulus(input bit ca, input logic [3:0] wa, input logic [4:0] aa, input logic [31:0] da,
                                 input bit cb, input logic [3:0] wb, input logic [4:0] ab, input logic [31:0] db,
                                 input bit cl);
        cea = ca; wea = wa; addra = aa; dina = da;
        ceb = cb; web = wb; addrb = ab; dinb = db;
        clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops, with a bound so a stuck engine still ends.
    task automatic waitBusyLow(output int n);
        n = 0;
        while (busy_d[0] && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        idle();
        repeat (3) tick();
        checkOutput("reset_busy", 0, 32'(busy_d[0]), 32'h1);
        checkOutput("reset_douta", 0, douta_d[0], 32'h0);
        checkOutput("reset_coll", 0, 32'(coll_d[0]), 32'h0);

        reset = 1'b0;
        waitBusyLow(n);
        checkOutput("clear_cycles_after_reset", 0, 32'(n), 32'd16);

        applyStimulus(1, 4'h0, 5'd3, 0, 1, 4'h0, 5'd7, 0, 0);
        checkOutput("read_after_clear_a", 0, douta_d[0], 32'h0);
        checkOutput("read_after_clear_b", 0, doutb_d[0], 32'h0);
        checkOutput("perr_after_clear", 0, 32'(perra_d[0]), 32'h0);

        // Read-during-write on port A across the three modes.
        applyStimulus(1, 4'hF, 5'd3, 32'h11223344, 0, 4'h0, 5'd0, 0, 0);
        applyStimulus(0, 4'h0, 5'd0, 0, 0, 4'h0, 5'd0, 0, 0);
        applyStimulus(1, 4'b0101, 5'd3, 32'hAABBCCDD, 0, 4'h0, 5'd0, 0, 0);
        checkOutput("rf_old_word", 0, douta_d[0], 32'h11223344);
        checkOutput("wf_oreg_prior", 1, douta_d[1], 32'h11223344);
        checkOutput("nc_hold", 2, douta_d[2], 32'h0);
        applyStimulus(0, 4'h0, 5'd0, 0, 0, 4'h0, 5'd0, 0, 0);
        checkOutput("wf_oreg_merged", 1, douta_d[1], 32'h11BB33DD);
        applyStimulus(1, 4'h0, 5'd3, 0, 0, 4'h0, 5'd0, 0, 0);
        checkOutput("rf_readback", 0, douta_d[0], 32'h11BB33DD);

        // Both ports write address 5; A owns its two low lanes.
        applyStimulus(1, 4'b0011, 5'd5, 32'hFFFFFFFF, 1, 4'b1111, 5'd5, 32'h12345678, 0);
        checkOutput("coll_pulse", 0, 32'(coll_d[0]), 32'h1);
        applyStimulus(1, 4'h0, 5'd5, 0, 0, 4'h0, 5'd0, 0, 0);
        checkOutput("coll_one_cycle", 0, 32'(coll_d[0]), 32'h0);
        checkOutput("coll_readback", 0, douta_d[0], 32'h1234FFFF);

        // Clear requested mid-traffic; a write while busy must vanish.
        applyStimulus(1, 4'hF, 5'd2, 32'hCAFEF00D, 1, 4'h0, 5'd3, 0, 0);
        applyStimulus(1, 4'h0, 5'd2, 0, 0, 4'h0, 5'd0, 0, 1);
        checkOutput("clr_busy", 0, 32'(busy_d[0]), 32'h1);
        checkOutput("read_on_clr_cycle", 0, douta_d[0], 32'hCAFEF00D);
        applyStimulus(1, 4'hF, 5'd2, 32'h55555555, 1, 4'h0, 5'd5, 0, 0);
        checkOutput("busy_hold_a", 0, douta_d[0], 32'hCAFEF00D);
        checkOutput("busy_hold_b", 0, doutb_d[0], 32'h11BB33DD);
        idle();
        waitBusyLow(n);
        // One edge of the sweep already elapsed during the ignored write.
        checkOutput("clr_cycles", 0, 32'(n), 32'd15);
        applyStimulus(1, 4'h0, 5'd2, 0, 0, 4'h0, 5'd0, 0, 0);
        checkOutput("cleared_addr2", 0, douta_d[0], 32'h0);

        // Reset while the sweep is at address 7.
        applyStimulus(0, 4'h0, 5'd0, 0, 0, 4'h0, 5'd0, 0, 1);
        idle();
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        waitBusyLow(n);
        checkOutput("clear_cycles_after_mid_reset", 0, 32'(n), 32'd16);

        // Out-of-range write must not alias onto address 0.
        applyStimulus(1, 4'hF, 5'd16, 32'hDEADBEEF, 1, 4'h0, 5'd0, 0, 0);
        applyStimulus(1, 4'h0, 5'd16, 0, 1, 4'h0, 5'd0, 0, 0);
        checkOutput("oob_read", 0, douta_d[0], 32'h0);
        checkOutput("oob_no_alias", 0, doutb_d[0], 32'h0);

`ifdef BSRAM_PARITY_EN
        // Flip one stored data bit at address 9 in every instance.
        g_dut[0].u_dut.mem[9][0] = ~g_dut[0].u_dut.mem[9][0];
        g_dut[1].u_dut.mem[9][0] = ~g_dut[1].u_dut.mem[9][0];
        g_dut[2].u_dut.mem[9][0] = ~g_dut[2].u_dut.mem[9][0];
        ref_mem[9][0] = ~ref_mem[9][0];
        ref_bad[9][0] = 1'b1;
        applyStimulus(0, 4'h0, 5'd0, 0, 1, 4'h0, 5'd9, 0, 0);
        checkOutput("poke_data", 0, doutb_d[0], 32'h1);
        checkOutput("poke_perr", 0, 32'(perrb_d[0]), 32'h1);
        applyStimulus(0, 4'h0, 5'd0, 0, 0, 4'h0, 5'd0, 0, 0);
        checkOutput("poke_perr_oreg", 1, 32'(perrb_d[1]), 32'h1);
        applyStimulus(0, 4'h0, 5'd0, 0, 1, 4'hF, 5'd9, 32'h0, 0);
`endif

        // Random traffic with frequent address matches and rare clears.
        for (int k = 0; k < 600; k++) begin
            bit          ca, cb, cl;
            logic [3:0]  wa, wb;
            logic [4:0]  aa, ab;
            ca = $urandom_range(0, 3) != 0;
            cb = $urandom_range(0, 3) != 0;
            wa = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            wb = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            aa = 5'($urandom_range(0, 17));
            ab = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 17));
            cl = $urandom_range(0, 79) == 0;
            applyStimulus(ca, wa, aa, $urandom, cb, wb, ab, $urandom, cl);
        end

        idle();
        waitBusyLow(n);
        checkOutput("final_idle", 0, 32'(busy_d[0]), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
